// File: rtl/saturn_char_tx.sv
// Buffered 8N1 serial character transmitter: FIFO feeding a start/data/stop framer.
// o_tx is registered from the current state, so the line trails the FSM by one clock.
module saturn_char_tx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_AW      = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         i_char,
    input  logic               i_char_valid,
    output logic               o_char_ready,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_overflow,
    output logic [FIFO_AW:0]   o_fifo_count
);

    // state   | meaning
    // S_IDLE  | line high, pop FIFO head when available
    // S_START | start bit (low) for CLKS_PER_BIT clocks
    // S_DATA  | eight data bits, LSB first
    // S_STOP  | stop bit (high) for CLKS_PER_BIT clocks
    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    localparam int          DEPTH     = 2 ** FIFO_AW;
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t             r_state;
    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic [7:0]         r_shift;
    logic [15:0]        r_baud;
    logic [2:0]         r_bit_idx;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_baud_end;

    // Occupancy never exceeds DEPTH, so the count MSB alone flags full.
    assign w_full       = r_count[FIFO_AW];
    assign w_empty      = (r_count == '0);
    assign o_char_ready = !reset && !w_full;
    assign w_push       = i_char_valid && o_char_ready;
    assign w_pop        = (r_state == S_IDLE) && !w_empty && !reset;
    assign w_baud_end   = (r_baud == BAUD_LAST);
    assign o_fifo_count = r_count;
    assign o_busy       = (r_state != S_IDLE) || !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_char;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_overflow <= 1'b0;
        end else if (i_char_valid && !o_char_ready) begin
            o_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            o_tx      <= 1'b1;
            r_shift   <= '0;
            r_baud    <= '0;
            r_bit_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    o_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift   <= r_mem[r_rd_ptr];
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    o_tx <= 1'b0;
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                S_DATA: begin
                    o_tx <= r_shift[0];
                    if (w_baud_end) begin
                        r_baud    <= '0;
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                S_STOP: begin
                    o_tx <= 1'b1;
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                default: begin
                    o_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_saturn_char_tx.sv
// Bench for saturn_char_tx: frame-position reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_saturn_char_tx;

    localparam int C  = 4;
    localparam int AW = 3;

    logic          clk;
    logic          reset;
    logic [7:0]    tb_char;
    logic          tb_valid;
    logic          o_char_ready;
    logic          o_tx;
    logic          o_busy;
    logic          o_overflow;
    logic [AW:0]   o_fifo_count;

    saturn_char_tx #(.CLKS_PER_BIT(C), .FIFO_AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_char       (tb_char),
        .i_char_valid (tb_valid),
        .o_char_ready (o_char_ready),
        .o_tx         (o_tx),
        .o_busy       (o_busy),
        .o_overflow   (o_overflow),
        .o_fifo_count (o_fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending chars in a queue, in-flight frame tracked by elapsed clocks.
    logic [7:0] mq[$];
    logic [7:0] m_cur;
    int         m_k      = 0;
    bit         m_active = 0;
    bit         m_ovf    = 0;
    logic       m_tx     = 1'b1;
    bit         started  = 0;

    function automatic logic frame_level(input logic [7:0] ch, input int k);
        int b;
        b = k / C;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return ch[b-1];
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            started = 1;
            if (reset) begin
                mq.delete();
                m_ovf    = 0;
                m_active = 0;
                m_tx     = 1'b1;
            end else begin
                int  pre_size;
                bit  rdy;
                pre_size = mq.size();
                rdy      = (pre_size < 2 ** AW);
                if (m_active) begin
                    m_tx = frame_level(m_cur, m_k);
                    m_k++;
                    if (m_k == 10 * C) m_active = 0;
                end else begin
                    m_tx = 1'b1;
                    if (pre_size > 0) begin
                        m_cur    = mq.pop_front();
                        m_active = 1;
                        m_k      = 0;
                    end
                end
                if (tb_valid) begin
                    if (rdy) mq.push_back(tb_char);
                    else     m_ovf = 1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                chk("model_tx",    32'(o_tx),         32'(m_tx));
                chk("model_count", 32'(o_fifo_count), 32'(mq.size()));
                chk("model_ovf",   32'(o_overflow),   32'(m_ovf));
                chk("model_busy",  32'(o_busy),       32'(m_active || mq.size() != 0));
                chk("model_ready", 32'(o_char_ready), 32'(!reset && mq.size() < 2 ** AW));
            end
        end
    end

    // Serial decoder, mid-bit sampling; only enabled for the ordering scenario.
    bit         dec_en = 0;
    logic [7:0] dec_b;
    logic [7:0] dec_q[$];

    initial begin
        forever begin
            @(negedge clk);
            if (dec_en && o_tx === 1'b0) begin
                repeat (C / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge clk);
                    dec_b[i] = o_tx;
                end
                repeat (C) @(negedge clk);
                dec_q.push_back(dec_b);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (o_busy && n < 2000) begin
            step();
            n++;
        end
        chk(name, 32'(n < 2000), 32'd1);
    endtask

    logic [9:0] exp41;
    int         cyc, fall1, rise1, fall2, rise2, idle_at;
    logic       prev_tx;
    bit         saw_fall;

    initial begin
        reset    = 1'b1;
        tb_valid = 1'b1;
        tb_char  = 8'hAA;
        #1;
        step(); step(); step();
        @(negedge clk);
        chk("rst_ready", 32'(o_char_ready), 32'd0);
        chk("rst_ovf",   32'(o_overflow),   32'd0);
        chk("rst_tx",    32'(o_tx),         32'd1);
        chk("rst_count", 32'(o_fifo_count), 32'd0);
        chk("rst_busy",  32'(o_busy),       32'd0);
        step();
        reset    = 1'b0;
        tb_valid = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(o_char_ready), 32'd1);
        step();

        // Single character 0x41 with latency pinning.
        exp41    = 10'b1010000010;
        tb_valid = 1'b1;
        tb_char  = 8'h41;
        step();
        tb_valid = 1'b0;
        @(negedge clk);
        chk("lat_count_n",  32'(o_fifo_count), 32'd1);
        chk("lat_tx_n",     32'(o_tx),         32'd1);
        step();
        @(negedge clk);
        chk("lat_tx_n1",    32'(o_tx),         32'd1);
        chk("lat_count_n1", 32'(o_fifo_count), 32'd0);
        chk("lat_busy_n1",  32'(o_busy),       32'd1);
        step();
        for (int k = 0; k < 10 * C; k++) begin
            @(negedge clk);
            chk("char41_bit", 32'(o_tx), 32'(exp41[k / C]));
            step();
        end
        @(negedge clk);
        chk("char41_idle_busy", 32'(o_busy), 32'd0);
        chk("char41_idle_tx",   32'(o_tx),   32'd1);

        // Fill: ten pushes on consecutive edges, first one drains immediately.
        step();
        tb_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tb_char = 8'(i + 1);
            step();
        end
        tb_valid = 1'b0;
        @(negedge clk);
        chk("fill_count", 32'(o_fifo_count), 32'd8);
        chk("fill_ready", 32'(o_char_ready), 32'd0);
        chk("fill_ovf",   32'(o_overflow),   32'd1);

        // One-cycle reset clears the sticky overflow.
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rstovf_ovf",   32'(o_overflow),   32'd0);
        chk("rstovf_ready", 32'(o_char_ready), 32'd1);
        chk("rstovf_count", 32'(o_fifo_count), 32'd0);
        chk("rstovf_tx",    32'(o_tx),         32'd1);
        step();

        // Back-to-back 0x00 then 0xFF.
        tb_valid = 1'b1;
        tb_char  = 8'h00;
        step();
        tb_char  = 8'hFF;
        step();
        tb_valid = 1'b0;
        fall1 = -1; rise1 = -1; fall2 = -1; rise2 = -1; idle_at = -1;
        prev_tx = 1'b1;
        cyc     = 0;
        while (cyc < 300 && idle_at < 0) begin
            @(negedge clk);
            if (prev_tx && !o_tx) begin
                if (fall1 < 0) fall1 = cyc; else if (fall2 < 0) fall2 = cyc;
            end
            if (!prev_tx && o_tx) begin
                if (rise1 < 0) rise1 = cyc; else if (rise2 < 0) rise2 = cyc;
            end
            if (fall2 >= 0 && !o_busy) idle_at = cyc;
            prev_tx = o_tx;
            step();
            cyc++;
        end
        chk("b2b_done",     32'(idle_at >= 0),  32'd1);
        chk("b2b_low1",     32'(rise1 - fall1), 32'd36);
        chk("b2b_gap",      32'(fall2 - fall1), 32'd41);
        chk("b2b_start2",   32'(rise2 - fall2), 32'd4);
        chk("b2b_busy_end", 32'(idle_at - fall1), 32'd80);
        repeat (3) step();

        // Wrap: 20 characters through the 8-deep FIFO, decoded off the line.
        dec_q.delete();
        dec_en = 1;
        for (int i = 0; i < 20; i++) begin
            int n;
            tb_char  = 8'(i);
            tb_valid = 1'b0;
            n = 0;
            while (!o_char_ready && n < 1000) begin
                step();
                n++;
            end
            chk("wrap_wait", 32'(n < 1000), 32'd1);
            tb_valid = 1'b1;
            step();
        end
        tb_valid = 1'b0;
        wait_idle("wrap_drain");
        repeat (3 * C) step();
        dec_en = 0;
        chk("wrap_n", 32'(dec_q.size()), 32'd20);
        for (int i = 0; i < dec_q.size() && i < 20; i++) begin
            chk("wrap_order", 32'(dec_q[i]), 32'(i));
        end
        @(negedge clk);
        chk("wrap_ovf",   32'(o_overflow),   32'd0);
        chk("wrap_count", 32'(o_fifo_count), 32'd0);
        step();

        // Reset during data bit 3 with three characters queued.
        tb_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tb_char = 8'hA0 + 8'(i);
            step();
        end
        tb_valid = 1'b0;
        repeat (15) step();
        @(negedge clk);
        chk("midrst_pre_count", 32'(o_fifo_count), 32'd3);
        chk("midrst_pre_busy",  32'(o_busy),       32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_tx",    32'(o_tx),         32'd1);
        chk("midrst_count", 32'(o_fifo_count), 32'd0);
        chk("midrst_busy",  32'(o_busy),       32'd0);
        saw_fall = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            @(negedge clk);
            if (!o_tx || o_busy) saw_fall = 1;
        end
        chk("midrst_quiet", 32'(saw_fall), 32'd0);
        step();

        // Randomized traffic at several offered loads, occasional reset.
        for (int phase = 0; phase < 3; phase++) begin
            int pct;
            pct = (phase == 0) ? 30 : (phase == 1) ? 3 : 90;
            for (int i = 0; i < 1500; i++) begin
                tb_valid = ($urandom_range(0, 99) < pct);
                tb_char  = 8'($urandom);
                reset    = ($urandom_range(0, 499) == 0);
                step();
            end
        end
        tb_valid = 1'b0;
        reset    = 1'b0;
        wait_idle("rand_drain");
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
